// File: rtl/jedro_1_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jedro_1_csr_pkg
// Brief    : Shared definitions for the jedro_1 machine-mode CSR / trap unit:
//            CSR addresses, access opcodes, trap sequencer states, cause codes.
// Revision : 1.0 - initial release
// ============================================================================
package jedro_1_csr_pkg;

    // Machine trap-setup / trap-handling CSRs
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;

    // Machine counters (writable) and their user read-only shadows
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // mcause codes raised by this unit
    localparam logic [31:0] CAUSE_ILLEGAL_INSTR = 32'd2;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        TRAP_IDLE     = 2'b00,
        TRAP_SAVE     = 2'b01,
        TRAP_REDIRECT = 2'b10,
        TRAP_RETURN   = 2'b11
    } trap_state_e;

    // New CSR value for a read-modify-write access; a no-op keeps the old value
    function automatic logic [31:0] csr_apply_op(input csr_op_e     op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] operand);
        logic [31:0] result;
        case (op)
            CSR_OP_RW: result = operand;
            CSR_OP_RS: result = old_val | operand;
            CSR_OP_RC: result = old_val & ~operand;
            default:   result = old_val;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jedro_1_csr_counter.sv
`default_nettype none
// ============================================================================
// Module   : jedro_1_csr_counter
// Brief    : 64-bit free-running counter with independent 32-bit half writes.
//            A write to either half suppresses the increment for that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module jedro_1_csr_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    // Next count: half writes win over increment; increment wraps naturally
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[31:0]  = wdata_i;
            if (wr_hi_i) cnt_d[63:32] = wdata_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign value_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/jedro_1_csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : jedro_1_csr_trap_unit
// Brief    : Machine-mode CSR file and trap sequencer for the jedro_1 core.
//            Executes CSRRW/RS/RC, raises illegal-instruction traps for bad
//            accesses, sequences trap entry (save -> redirect to mtvec) and
//            MRET return (redirect to mepc).
//            Optional: define JEDRO_1_CSR_COUNTERS_EN to add the 64-bit
//            mcycle/minstret counters and their cycle/instret shadows.
// Revision : 1.0 - initial release
// ============================================================================
module jedro_1_csr_trap_unit
    import jedro_1_csr_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_SCRATCH = 1,
    parameter logic [31:0] MTVEC_RESET = 32'h0,
    parameter int          NUM_CAUSES  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  csr_valid_i,
    input  logic [1:0]            csr_op_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [DATA_WIDTH-1:0] csr_wdata_i,
    input  logic                  csr_write_i,
    output logic [DATA_WIDTH-1:0] csr_rdata_o,
    output logic                  csr_done_o,
    output logic                  illegal_csr_o,
    input  logic                  exc_req_i,
    input  logic [3:0]            exc_cause_i,
    input  logic [31:0]           exc_pc_i,
    input  logic [31:0]           exc_tval_i,
    input  logic                  mret_i,
    input  logic                  instret_i,
    output logic                  busy_o,
    output logic                  redirect_o,
    output logic [31:0]           redirect_pc_o
);

    localparam logic [31:0] NUM_CAUSES_W = 32'(NUM_CAUSES);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("jedro_1_csr_trap_unit: only DATA_WIDTH=32 is supported");
        end
        if (NUM_SCRATCH < 1 || NUM_SCRATCH > 4) begin : g_bad_num_scratch
            $error("jedro_1_csr_trap_unit: NUM_SCRATCH must be 1..4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    trap_state_e state_q, state_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] scratch_q [NUM_SCRATCH];
    logic [31:0] scratch_d [NUM_SCRATCH];
    logic        csr_done_q, csr_done_d;
    logic        illegal_q, illegal_d;
    logic [31:0] rdata_q, rdata_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                   csr_hit;
    logic [31:0]            csr_old;
    logic                   sel_mtvec, sel_mepc, sel_mcause, sel_mtval;
    logic [NUM_SCRATCH-1:0] sel_scratch;
`ifdef JEDRO_1_CSR_COUNTERS_EN
    logic                   sel_mcycle, sel_mcycleh, sel_minstret, sel_minstreth;
    logic [63:0]            mcycle_val, minstret_val;
`endif

    // Decode the address into a hit flag, the current value and a write select.
    // Trap CSRs are matched before the scratch range, so with NUM_SCRATCH > 1
    // the fixed mepc/mcause/mtval addresses keep their meaning.
    always_comb begin
        csr_hit     = 1'b0;
        csr_old     = '0;
        sel_mtvec   = 1'b0;
        sel_mepc    = 1'b0;
        sel_mcause  = 1'b0;
        sel_mtval   = 1'b0;
        sel_scratch = '0;
`ifdef JEDRO_1_CSR_COUNTERS_EN
        sel_mcycle    = 1'b0;
        sel_mcycleh   = 1'b0;
        sel_minstret  = 1'b0;
        sel_minstreth = 1'b0;
`endif
        case (csr_addr_i)
            CSR_MTVEC:  begin csr_hit = 1'b1; sel_mtvec  = 1'b1; csr_old = mtvec_q;  end
            CSR_MEPC:   begin csr_hit = 1'b1; sel_mepc   = 1'b1; csr_old = mepc_q;   end
            CSR_MCAUSE: begin csr_hit = 1'b1; sel_mcause = 1'b1; csr_old = mcause_q; end
            CSR_MTVAL:  begin csr_hit = 1'b1; sel_mtval  = 1'b1; csr_old = mtval_q;  end
`ifdef JEDRO_1_CSR_COUNTERS_EN
            CSR_MCYCLE:    begin csr_hit = 1'b1; sel_mcycle    = 1'b1; csr_old = mcycle_val[31:0];    end
            CSR_MCYCLEH:   begin csr_hit = 1'b1; sel_mcycleh   = 1'b1; csr_old = mcycle_val[63:32];   end
            CSR_MINSTRET:  begin csr_hit = 1'b1; sel_minstret  = 1'b1; csr_old = minstret_val[31:0];  end
            CSR_MINSTRETH: begin csr_hit = 1'b1; sel_minstreth = 1'b1; csr_old = minstret_val[63:32]; end
            CSR_CYCLE:     begin csr_hit = 1'b1; csr_old = mcycle_val[31:0];    end
            CSR_CYCLEH:    begin csr_hit = 1'b1; csr_old = mcycle_val[63:32];   end
            CSR_INSTRET:   begin csr_hit = 1'b1; csr_old = minstret_val[31:0];  end
            CSR_INSTRETH:  begin csr_hit = 1'b1; csr_old = minstret_val[63:32]; end
`endif
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (csr_addr_i == CSR_MSCRATCH + 12'(i)) begin
                        csr_hit        = 1'b1;
                        sel_scratch[i] = 1'b1;
                        csr_old        = scratch_q[i];
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Event arbitration (only while IDLE): exc > illegal CSR > mret > CSR
    // ------------------------------------------------------------------
    csr_op_e     csr_op;
    logic        csr_wr, idle, csr_req, csr_bad;
    logic        take_exc, take_ill, take_mret, take_csr, csr_we;
    logic [31:0] csr_new, cause_ext;

    assign csr_op    = csr_op_e'(csr_op_i);
    assign csr_wr    = csr_write_i && (csr_op != CSR_OP_NONE);
    assign idle      = (state_q == TRAP_IDLE);
    assign csr_req   = idle && csr_valid_i;
    assign csr_bad   = csr_req && (!csr_hit || (csr_wr && (csr_addr_i[11:10] == 2'b11)));
    assign take_exc  = idle && exc_req_i;
    assign take_ill  = csr_bad && !exc_req_i;
    assign take_mret = idle && mret_i && !exc_req_i && !csr_bad;
    assign take_csr  = csr_req && !csr_bad && !exc_req_i && !mret_i;
    assign csr_we    = take_csr && csr_wr;
    assign csr_new   = csr_apply_op(csr_op, csr_old, csr_wdata_i);
    assign cause_ext = ({28'd0, exc_cause_i} >= NUM_CAUSES_W) ? 32'd0 : {28'd0, exc_cause_i};

    // Trap sequencer next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            TRAP_IDLE: begin
                if (take_exc || take_ill) state_d = TRAP_SAVE;
                else if (take_mret)       state_d = TRAP_RETURN;
            end
            TRAP_SAVE:     state_d = TRAP_REDIRECT;
            TRAP_REDIRECT: state_d = TRAP_IDLE;
            TRAP_RETURN:   state_d = TRAP_IDLE;
            default:       state_d = TRAP_IDLE;
        endcase
    end

    // CSR register updates: trap save on entry, otherwise legal CSR writes
    always_comb begin
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        scratch_d  = scratch_q;
        csr_done_d = take_csr;
        illegal_d  = take_ill;
        rdata_d    = take_csr ? csr_old : 32'd0;
        if (take_exc || take_ill) begin
            mepc_d   = exc_pc_i & ~32'h3;
            mcause_d = take_exc ? cause_ext : CAUSE_ILLEGAL_INSTR;
            mtval_d  = take_exc ? exc_tval_i : 32'd0;
        end else if (csr_we) begin
            if (sel_mtvec)  mtvec_d  = {csr_new[31:2], 2'b00};
            if (sel_mepc)   mepc_d   = {csr_new[31:2], 2'b00};
            if (sel_mcause) mcause_d = csr_new;
            if (sel_mtval)  mtval_d  = csr_new;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (sel_scratch[i]) scratch_d[i] = csr_new;
            end
        end
    end

    // State and CSR registers; reset returns straight to IDLE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= TRAP_IDLE;
            mtvec_q    <= MTVEC_RESET & ~32'h3;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
            csr_done_q <= 1'b0;
            illegal_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            scratch_q  <= scratch_d;
            csr_done_q <= csr_done_d;
            illegal_q  <= illegal_d;
            rdata_q    <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional counters
    // ------------------------------------------------------------------
`ifdef JEDRO_1_CSR_COUNTERS_EN
    jedro_1_csr_counter u_mcycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (1'b1),
        .wr_lo_i (csr_we && sel_mcycle),
        .wr_hi_i (csr_we && sel_mcycleh),
        .wdata_i (csr_new),
        .value_o (mcycle_val)
    );

    jedro_1_csr_counter u_minstret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (instret_i),
        .wr_lo_i (csr_we && sel_minstret),
        .wr_hi_i (csr_we && sel_minstreth),
        .wdata_i (csr_new),
        .value_o (minstret_val)
    );
`else
    logic unused_instret;
    assign unused_instret = instret_i;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign csr_rdata_o   = rdata_q;
    assign csr_done_o    = csr_done_q;
    assign illegal_csr_o = illegal_q;
    assign busy_o        = (state_q != TRAP_IDLE);
    assign redirect_o    = (state_q == TRAP_REDIRECT) || (state_q == TRAP_RETURN);
    assign redirect_pc_o = (state_q == TRAP_REDIRECT) ? mtvec_q :
                           (state_q == TRAP_RETURN)   ? mepc_q  : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_jedro_1_csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_jedro_1_csr_trap_unit
// Brief    : Directed self-checking bench for jedro_1_csr_trap_unit
//            (MTVEC_RESET = 32'h100). Follows JEDRO_1_CSR_COUNTERS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jedro_1_csr_trap_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_valid = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_done;
    logic        illegal_csr;
    logic        exc_req = 1'b0;
    logic [3:0]  exc_cause = '0;
    logic [31:0] exc_pc = '0;
    logic [31:0] exc_tval = '0;
    logic        mret = 1'b0;
    logic        instret = 1'b0;
    logic        busy;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    jedro_1_csr_trap_unit #(
        .DATA_WIDTH  (32),
        .NUM_SCRATCH (1),
        .MTVEC_RESET (32'h100),
        .NUM_CAUSES  (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .csr_valid_i   (csr_valid),
        .csr_op_i      (csr_op),
        .csr_addr_i    (csr_addr),
        .csr_wdata_i   (csr_wdata),
        .csr_write_i   (csr_write),
        .csr_rdata_o   (csr_rdata),
        .csr_done_o    (csr_done),
        .illegal_csr_o (illegal_csr),
        .exc_req_i     (exc_req),
        .exc_cause_i   (exc_cause),
        .exc_pc_i      (exc_pc),
        .exc_tval_i    (exc_tval),
        .mret_i        (mret),
        .instret_i     (instret),
        .busy_o        (busy),
        .redirect_o    (redirect),
        .redirect_pc_o (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        csr_valid = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0; csr_write = 1'b0;
        exc_req = 1'b0; exc_cause = '0; exc_tval = '0; mret = 1'b0;
    endtask

    // One-cycle CSR request; on return the registered response is visible
    task automatic req(input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic wr);
        csr_valid = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wdata; csr_write = wr;
        tick();
        clear_inputs();
    endtask

    task automatic read_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        req(OP_RS, addr, 32'h0, 1'b0);
        chk({tag, "_done"}, {31'd0, csr_done}, 32'd1);
        chk(tag, csr_rdata, exp);
    endtask

    initial begin
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_done",     {31'd0, csr_done},    32'd0);
        chk("rst_illegal",  {31'd0, illegal_csr}, 32'd0);
        chk("rst_busy",     {31'd0, busy},        32'd0);
        chk("rst_redirect", {31'd0, redirect},    32'd0);
        chk("rst_rpc",      redirect_pc,          32'd0);
        chk("rst_rdata",    csr_rdata,            32'd0);
        rst = 1'b0;

        // mtvec reset value
        read_csr("mtvec_reset", 12'h305, 32'h100);
        chk("mtvec_reset_redirect", {31'd0, redirect}, 32'd0);

        // Scratch RW / RS / RC
        req(OP_RW, 12'h340, 32'hDEAD_BEEF, 1'b1);
        chk("scr_rw_old", csr_rdata, 32'h0);
        req(OP_RS, 12'h340, 32'h0000_000F, 1'b1);
        chk("scr_rs_old", csr_rdata, 32'hDEAD_BEEF);
        req(OP_RC, 12'h340, 32'h0000_00F0, 1'b1);
        chk("scr_rc_old", csr_rdata, 32'hDEAD_BEEF);
        read_csr("scr_final", 12'h340, 32'hDEAD_BE0F);

        // mtvec write drops the low two bits
        req(OP_RW, 12'h305, 32'h0000_0203, 1'b1);
        chk("mtvec_wr_old", csr_rdata, 32'h100);
        read_csr("mtvec_new", 12'h305, 32'h200);

        // Non-existent CSR -> illegal trap; requests during busy ignored
        exc_pc = 32'h24;
        req(OP_RS, 12'h7FF, 32'h0, 1'b0);
        chk("ill_pulse",    {31'd0, illegal_csr}, 32'd1);
        chk("ill_done",     {31'd0, csr_done},    32'd0);
        chk("ill_rdata",    csr_rdata,            32'd0);
        chk("ill_busy",     {31'd0, busy},        32'd1);
        chk("ill_noredir",  {31'd0, redirect},    32'd0);
        mret = 1'b1;
        req(OP_RS, 12'h340, 32'h0, 1'b0);
        chk("ill_redirect", {31'd0, redirect},    32'd1);
        chk("ill_rpc",      redirect_pc,          32'h200);
        chk("busy_ign_done", {31'd0, csr_done},   32'd0);
        chk("ill_pulse_end", {31'd0, illegal_csr}, 32'd0);
        tick();
        chk("ill_idle_busy",  {31'd0, busy},     32'd0);
        chk("ill_idle_redir", {31'd0, redirect}, 32'd0);
        read_csr("ill_mcause", 12'h342, 32'd2);
        read_csr("ill_mepc",   12'h341, 32'h24);
        read_csr("ill_mtval",  12'h343, 32'd0);

        // MRET returns to mepc
        mret = 1'b1;
        tick();
        mret = 1'b0;
        chk("mret_redirect", {31'd0, redirect}, 32'd1);
        chk("mret_rpc",      redirect_pc,       32'h24);
        chk("mret_busy",     {31'd0, busy},     32'd1);
        tick();
        chk("mret_idle", {31'd0, busy}, 32'd0);

        // Write to read-only cycle CSR -> illegal, epc aligned
        exc_pc = 32'h33;
        req(OP_RW, 12'hC00, 32'h1234, 1'b1);
        chk("ro_illegal", {31'd0, illegal_csr}, 32'd1);
        chk("ro_done",    {31'd0, csr_done},    32'd0);
        tick();
        tick();
        read_csr("ro_mepc", 12'h341, 32'h30);

        // External exception beats a legal CSR access in the same cycle
        exc_req = 1'b1; exc_cause = 4'd5; exc_tval = 32'h0000_ABCD; exc_pc = 32'h46;
        req(OP_RS, 12'h340, 32'h0, 1'b0);
        chk("exc_done",    {31'd0, csr_done},    32'd0);
        chk("exc_illegal", {31'd0, illegal_csr}, 32'd0);
        chk("exc_busy",    {31'd0, busy},        32'd1);
        tick();
        chk("exc_rpc", redirect_pc, 32'h200);
        tick();
        read_csr("exc_mcause", 12'h342, 32'd5);
        read_csr("exc_mtval",  12'h343, 32'h0000_ABCD);
        read_csr("exc_mepc",   12'h341, 32'h44);

        // MRET beats a legal CSR access
        mret = 1'b1;
        req(OP_RS, 12'h340, 32'h0, 1'b0);
        chk("mret_csr_done", {31'd0, csr_done}, 32'd0);
        chk("mret_csr_rpc",  redirect_pc,       32'h44);
        tick();

        // mepc write drops the low two bits
        req(OP_RW, 12'h341, 32'h57, 1'b1);
        read_csr("mepc_align", 12'h341, 32'h54);

`ifdef JEDRO_1_CSR_COUNTERS_EN
        req(OP_RW, 12'hB00, 32'hFFFF_FFFF, 1'b1);
        chk("mcycle_wr_done", {31'd0, csr_done}, 32'd1);
        tick();
        read_csr("mcycleh", 12'hB80, 32'd1);
        read_csr("cycleh",  12'hC80, 32'd1);
`else
        req(OP_RS, 12'hB00, 32'h0, 1'b0);
        chk("cnt_off_illegal", {31'd0, illegal_csr}, 32'd1);
        chk("cnt_off_done",    {31'd0, csr_done},    32'd0);
        tick();
        tick();
`endif

        // Reset in the middle of a trap sequence
        exc_req = 1'b1; exc_cause = 4'd3; exc_pc = 32'h80;
        tick();
        clear_inputs();
        chk("midrst_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy",  {31'd0, busy},     32'd0);
        chk("midrst_redir", {31'd0, redirect}, 32'd0);
        tick();
        chk("midrst_redir2", {31'd0, redirect}, 32'd0);
        rst = 1'b0;
        read_csr("midrst_mtvec",   12'h305, 32'h100);
        read_csr("midrst_scratch", 12'h340, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
